// File: rtl/bitwise_or_if.sv
// Operand/result bundle for the registered bitwise-OR slice.
// Optional combinational bypass output is present only when
// BITWISE_OR_BYPASS_EN is defined.
interface bitwise_or_if #(
   parameter int N = 32
);
   localparam int CW = $clog2(N + 1);

   logic          in_valid;
   logic [N-1:0]  in1;
   logic [N-1:0]  in2;
   logic [N-1:0]  out;
   logic          out_valid;
   logic          zero;
   logic          neg;
   logic [CW-1:0] ones;
`ifdef BITWISE_OR_BYPASS_EN
   logic [N-1:0]  out_comb;
`endif

`ifdef BITWISE_OR_BYPASS_EN
   modport master (
      output in_valid, in1, in2,
      input  out, out_valid, zero, neg, ones, out_comb
   );
   modport slave (
      input  in_valid, in1, in2,
      output out, out_valid, zero, neg, ones, out_comb
   );
`else
   modport master (
      output in_valid, in1, in2,
      input  out, out_valid, zero, neg, ones
   );
   modport slave (
      input  in_valid, in1, in2,
      output out, out_valid, zero, neg, ones
   );
`endif
endinterface

// File: rtl/bitwise_or.sv
// Registered N-bit bitwise OR with zero/negative flags and population count.
// One-cycle latency, one result per cycle, no backpressure.
// Optional: BITWISE_OR_BYPASS_EN adds a purely combinational out_comb = in1 | in2.
module bitwise_or #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   bitwise_or_if.slave  bus
);
   localparam int CW = $clog2(N + 1);

   // Count of set bits; unrolled into a combinational adder network.
   function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   logic [N-1:0]  or_s;
   logic          zero_s;
   logic          neg_s;
   logic [CW-1:0] ones_s;

   logic [N-1:0]  out_r;
   logic          out_valid_r;
   logic          zero_r;
   logic          neg_r;
   logic [CW-1:0] ones_r;

   // OR result and its status flags, computed ahead of the output registers.
   always_comb begin
      or_s   = bus.in1 | bus.in2;
      zero_s = (or_s == '0);
      neg_s  = or_s[N-1];
      ones_s = popcount(or_s);
   end

   // Output registers: reset clears, a valid operand pair loads, otherwise hold
   // (operands are ignored while in_valid is low, so X there cannot leak in).
   always_ff @(posedge clk) begin
      if (reset) begin
         out_r       <= '0;
         out_valid_r <= 1'b0;
         zero_r      <= 1'b0;
         neg_r       <= 1'b0;
         ones_r      <= '0;
      end else if (bus.in_valid) begin
         out_r       <= or_s;
         out_valid_r <= 1'b1;
         zero_r      <= zero_s;
         neg_r       <= neg_s;
         ones_r      <= ones_s;
      end else begin
         out_r       <= out_r;
         out_valid_r <= 1'b0;
         zero_r      <= zero_r;
         neg_r       <= neg_r;
         ones_r      <= ones_r;
      end
   end

   assign bus.out       = out_r;
   assign bus.out_valid = out_valid_r;
   assign bus.zero      = zero_r;
   assign bus.neg       = neg_r;
   assign bus.ones      = ones_r;

`ifdef BITWISE_OR_BYPASS_EN
   // Zero-latency path for single-cycle datapaths; ignores in_valid and reset.
   assign bus.out_comb = or_s;
`endif

endmodule

// File: tb/tb_bitwise_or.sv
// Self-checking bench for bitwise_or (N=32), plus an N=8 bypass check when
// BITWISE_OR_BYPASS_EN is defined.
module tb_bitwise_or;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   // Reference state: what the outputs should show after the latest edge.
   logic [31:0] m_out;
   logic        m_valid;
   logic        m_zero;
   logic        m_neg;
   int          m_ones;

   bitwise_or_if #(.N(32)) bus ();
   bitwise_or #(.N(32)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef BITWISE_OR_BYPASS_EN
   bitwise_or_if #(.N(8)) bus8 ();
   bitwise_or #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"},       64'(bus.out),       64'(m_out));
      check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
      check({tag, ".zero"},      64'(bus.zero),      64'(m_zero));
      check({tag, ".neg"},       64'(bus.neg),       64'(m_neg));
      check({tag, ".ones"},      64'(bus.ones),      64'(m_ones));
   endtask

   // One clock: drive on the falling edge, update the model from the rules, compare after the rising edge.
   task automatic cycle(input string tag, input logic r, input logic v,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      reset        = r;
      bus.in_valid = v;
      bus.in1      = a;
      bus.in2      = b;
      @(posedge clk);
      #1;
      if (r) begin
         m_out = 32'd0; m_valid = 1'b0; m_zero = 1'b0; m_neg = 1'b0; m_ones = 0;
      end else if (v) begin
         m_out   = a | b;
         m_valid = 1'b1;
         m_zero  = (m_out == 32'd0);
         m_neg   = (m_out >= 32'h8000_0000);
         m_ones  = $countones(m_out);
      end else begin
         m_valid = 1'b0;
      end
      check_all(tag);
   endtask

   logic [39:0] wide_src;
   logic [31:0] ra;
   logic [31:0] rb;
   logic        rv;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in1 = 32'd0;
      bus.in2 = 32'd0;
`ifdef BITWISE_OR_BYPASS_EN
      bus8.in_valid = 1'b0;
      bus8.in1 = 8'd0;
      bus8.in2 = 8'd0;
`endif

      // Reset held two cycles with a valid all-ones operand: reset wins.
      cycle("rst0", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
      cycle("rst1", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
      check("rst.out_const", 64'(bus.out), 64'h0);
      check("rst.ones_const", 64'(bus.ones), 64'h0);

      // Small values back to back.
      cycle("small0", 1'b0, 1'b1, 32'h2, 32'h1);
      check("small0.out_const", 64'(bus.out), 64'h3);
      check("small0.ones_const", 64'(bus.ones), 64'd2);
      cycle("small1", 1'b0, 1'b1, 32'h2, 32'h2);
      check("small1.ones_const", 64'(bus.ones), 64'd1);
      cycle("small2", 1'b0, 1'b1, 32'hF, 32'h5);
      check("small2.out_const", 64'(bus.out), 64'hF);
      check("small2.valid_const", 64'(bus.out_valid), 64'd1);

      // Wide pattern with a 40-bit source truncated to 32 bits.
      wide_src = 40'h22_2222_2222;
      cycle("wide", 1'b0, 1'b1, 32'h5555_5555, wide_src[31:0]);
      check("wide.out_const", 64'(bus.out), 64'h7777_7777);
      check("wide.ones_const", 64'(bus.ones), 64'd24);

      // Flag boundaries.
      cycle("zero", 1'b0, 1'b1, 32'h0, 32'h0);
      check("zero.zero_const", 64'(bus.zero), 64'd1);
      cycle("neg", 1'b0, 1'b1, 32'h8000_0000, 32'h0);
      check("neg.neg_const", 64'(bus.neg), 64'd1);
      check("neg.ones_const", 64'(bus.ones), 64'd1);
      cycle("full", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("full.ones_const", 64'(bus.ones), 64'd32);

      // Hold: in_valid low, operands random (and once X); outputs must not move.
      cycle("hold_ref", 1'b0, 1'b1, 32'h0001_0200, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cycle("hold", 1'b0, 1'b0, $urandom, $urandom);
      end
      cycle("hold_x", 1'b0, 1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
      check("hold.out_const", 64'(bus.out), 64'h0001_0200);

      // Result in flight discarded by reset, then first result one cycle after release.
      cycle("flight", 1'b0, 1'b1, 32'h1234_5678, 32'h0);
      cycle("flight_rst", 1'b1, 1'b1, 32'hFFFF_0000, 32'h0);
      cycle("after_rst", 1'b0, 1'b1, 32'h0000_00F0, 32'h0000_000F);
      check("after_rst.out_const", 64'(bus.out), 64'hFF);

      // Randomized traffic against the model.
      for (int i = 0; i < 60; i++) begin
         rv = ($urandom_range(3, 0) != 0);
         ra = $urandom;
         rb = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
         cycle("rand", ($urandom_range(19, 0) == 0), rv, ra, rb);
      end

`ifdef BITWISE_OR_BYPASS_EN
      // Bypass: combinational result in the same cycle, registered one edge later.
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus8.in_valid = 1'b1;
      bus8.in1 = 8'hA0;
      bus8.in2 = 8'h05;
      #1;
      check("bypass.comb", 64'(bus8.out_comb), 64'hA5);
      @(posedge clk);
      #1;
      check("bypass.reg", 64'(bus8.out), 64'hA5);
      check("bypass.valid", 64'(bus8.out_valid), 64'd1);
      @(negedge clk);
      bus8.in_valid = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
